// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage control FSM for PC, IF/ID register, instruction memory and interrupt entry/exit
module fetch_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       intr,
    input  logic       int_en,
    input  logic       branch_taken,
    input  logic       jump,
    input  logic       load_use,
    input  logic       reti,
    input  logic       halt,
    output logic       pc_ld,
    output logic       pc_inc,
    output logic [1:0] pc_src,
    output logic       Stall,
    output logic       Flush,
    output logic       im_cs,
    output logic       im_rd,
    output logic       im_wr,
    output logic       ISR,
    output logic [2:0] LISR,
    output logic       intr_ack,
    output logic       save_pc,
    output logic       restore_pc,
    output logic       in_isr,
    output logic       halted
);
    typedef enum logic [2:0] {IDLE, RUN, ISR_SAVE, ISR_VEC, LISR_1, LISR_2, LISR_3, HALT} state_t;
    state_t state_q, state_d;
    logic   in_isr_q, in_isr_d;
    logic   take_int;
    assign take_int = intr & int_en & !in_isr_q;
    assign im_wr    = 1'b0;
    assign in_isr   = in_isr_q;
    // Next-state and strobe decode; RUN uses a fixed priority halt > reti > branch/jump > intr > load_use
    always_comb begin
        state_d    = state_q;
        in_isr_d   = in_isr_q;
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_src     = 2'd0;
        Stall      = 1'b0;
        Flush      = 1'b0;
        im_cs      = 1'b0;
        im_rd      = 1'b0;
        ISR        = 1'b0;
        LISR       = 3'b000;
        intr_ack   = 1'b0;
        save_pc    = 1'b0;
        restore_pc = 1'b0;
        halted     = 1'b0;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                im_cs = 1'b1;
                im_rd = 1'b1;
                if (halt) begin
                    Stall   = 1'b1;
                    state_d = HALT;
                end else if (reti && in_isr_q) begin
                    Flush   = 1'b1;
                    state_d = LISR_1;
                end else if (branch_taken || jump) begin
                    pc_ld  = 1'b1;
                    Flush  = 1'b1;
                    pc_src = jump ? 2'd1 : 2'd0;
                end else if (take_int) begin
                    intr_ack = 1'b1;
                    Stall    = 1'b1;
                    state_d  = ISR_SAVE;
                end else if (load_use) begin
                    Stall = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
            end
            ISR_SAVE: begin
                ISR     = 1'b1;
                save_pc = 1'b1;
                Stall   = 1'b1;
                state_d = ISR_VEC;
            end
            ISR_VEC: begin
                ISR      = 1'b1;
                pc_ld    = 1'b1;
                pc_src   = 2'd2;
                Flush    = 1'b1;
                in_isr_d = 1'b1;
                state_d  = RUN;
            end
            LISR_1: begin
                LISR    = 3'b001;
                Stall   = 1'b1;
                state_d = LISR_2;
            end
            LISR_2: begin
                LISR       = 3'b010;
                Stall      = 1'b1;
                restore_pc = 1'b1;
                state_d    = LISR_3;
            end
            LISR_3: begin
                LISR     = 3'b100;
                pc_ld    = 1'b1;
                pc_src   = 2'd3;
                Flush    = 1'b1;
                in_isr_d = 1'b0;
                state_d  = RUN;
            end
            HALT: begin
                halted = 1'b1;
                Stall  = 1'b1;
                if (take_int) begin
                    intr_ack = 1'b1;
                    state_d  = ISR_SAVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // State and ISR-context flops; asynchronous reset returns to IDLE outside any ISR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            in_isr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_isr_q <= in_isr_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: vector table plus scoreboard queue checking fetch_sequencer strobes cycle by cycle
module tb_fetch_sequencer;
    logic       clk, rst, intr, int_en, branch_taken, jump, load_use, reti, halt;
    logic       pc_ld, pc_inc, stall, flush, im_cs, im_rd, im_wr, isr, intr_ack, save_pc, restore_pc, in_isr, halted;
    logic [1:0] pc_src;
    logic [2:0] lisr;
    int compared = 0;
    int mismatched = 0;
    logic [17:0] exp_q[$];

    localparam logic [6:0] I_INT = 7'b1000000, I_EN = 7'b0100000, I_BR = 7'b0010000, I_JP = 7'b0001000;
    localparam logic [6:0] I_LU = 7'b0000100, I_RT = 7'b0000010, I_HL = 7'b0000001, I0 = 7'b0;
    localparam logic [17:0] PL = 18'd1 << 17, PI = 18'd1 << 16, SRC1 = 18'd1 << 14, SRC2 = 18'd2 << 14;
    localparam logic [17:0] SRC3 = 18'd3 << 14, ST = 18'd1 << 13, FL = 18'd1 << 12, FE = 18'd3 << 10;
    localparam logic [17:0] ISRB = 18'd1 << 8, L1 = 18'd1 << 5, L2 = 18'd1 << 6, L3 = 18'd1 << 7;
    localparam logic [17:0] ACK = 18'd1 << 4, SAVE = 18'd1 << 3, REST = 18'd1 << 2, INI = 18'd1 << 1, HLT = 18'd1;

    typedef struct {
        logic [6:0]  in;
        logic [17:0] ex;
    } vec_t;
    vec_t v[30];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .intr(intr), .int_en(int_en), .branch_taken(branch_taken), .jump(jump),
        .load_use(load_use), .reti(reti), .halt(halt), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_src(pc_src),
        .Stall(stall), .Flush(flush), .im_cs(im_cs), .im_rd(im_rd), .im_wr(im_wr), .ISR(isr), .LISR(lisr),
        .intr_ack(intr_ack), .save_pc(save_pc), .restore_pc(restore_pc), .in_isr(in_isr), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm);
        logic [17:0] got, e;
        got = {pc_ld, pc_inc, pc_src, stall, flush, im_cs, im_rd, im_wr, isr, lisr,
               intr_ack, save_pc, restore_pc, in_isr, halted};
        e = exp_q.pop_front();
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("FAIL %s: got %05h want %05h", nm, got, e);
        end
    endtask

    task automatic drive(input logic [6:0] in);
        {intr, int_en, branch_taken, jump, load_use, reti, halt} = in;
    endtask

    // caller sits at a falling edge; drive, check mid-low-phase, advance to next falling edge
    task automatic step(input logic [6:0] in, input logic [17:0] ex, input string nm);
        drive(in);
        exp_q.push_back(ex);
        #2;
        check(nm);
        @(negedge clk);
    endtask

    initial begin
        v[0]  = '{I0, 18'd0};
        v[1]  = '{I0, FE | PI};
        v[2]  = '{I_BR, FE | PL | FL};
        v[3]  = '{I0, FE | PI};
        v[4]  = '{I_JP, FE | PL | FL | SRC1};
        v[5]  = '{I_BR | I_JP, FE | PL | FL | SRC1};
        v[6]  = '{I_LU, FE | ST};
        v[7]  = '{I_LU, FE | ST};
        v[8]  = '{I0, FE | PI};
        v[9]  = '{I_RT, FE | PI};
        v[10] = '{I_INT, FE | PI};
        v[11] = '{I_INT | I_EN | I_BR, FE | PL | FL};
        v[12] = '{I_INT | I_EN, FE | ACK | ST};
        v[13] = '{I_INT | I_EN | I_HL, ISRB | SAVE | ST};
        v[14] = '{I_INT | I_EN, ISRB | PL | SRC2 | FL};
        v[15] = '{I_INT | I_EN, FE | PI | INI};
        v[16] = '{I_INT | I_EN | I_LU, FE | ST | INI};
        v[17] = '{I_RT, FE | FL | INI};
        v[18] = '{I_BR, L1 | ST | INI};
        v[19] = '{I0, L2 | ST | REST | INI};
        v[20] = '{I0, L3 | PL | SRC3 | FL | INI};
        v[21] = '{I0, FE | PI};
        v[22] = '{I_HL | I_BR, FE | ST};
        v[23] = '{I_BR, HLT | ST};
        v[24] = '{I_INT, HLT | ST};
        v[25] = '{I_INT | I_EN, HLT | ST | ACK};
        v[26] = '{I0, ISRB | SAVE | ST};
        v[27] = '{I0, ISRB | PL | SRC2 | FL};
        v[28] = '{I_HL, FE | ST | INI};
        v[29] = '{I_INT | I_EN, HLT | ST | INI};
        rst = 1'b1;
        drive(I0);
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back(18'd0);
        #2;
        check("reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) step(v[i].in, v[i].ex, $sformatf("vec%0d", i));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(I0, 18'd0, "idle_b");
        step(I_INT | I_EN, FE | ACK | ST, "ack_b");
        step(I0, ISRB | SAVE | ST, "save_b");
        step(I0, ISRB | PL | SRC2 | FL, "vec_b");
        step(I_RT, FE | FL | INI, "reti_b");
        step(I0, L1 | ST | INI, "lisr1_b");
        drive(I0);
        exp_q.push_back(L2 | ST | REST | INI);
        #2;
        check("lisr2_b");
        #1 rst = 1'b1;
        #1;
        exp_q.push_back(18'd0);
        check("rst_mid");
        @(negedge clk);
        exp_q.push_back(18'd0);
        check("rst_hold");
        rst = 1'b0;
        step(I0, 18'd0, "idle_c");
        step(I0, FE | PI, "run_c");
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL queue: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control FSM that sequences the fetch stage (PC register, instruction memory, IF/ID register) of the pipelined MIPS core. Each cycle it issues the PC load/increment strobes, IF/ID stall/flush, instruction-memory enables and the interrupt entry/exit handshakes. Inputs are the decoded branch/jump, hazard, interrupt and return-from-interrupt conditions from the ID stage and the interrupt controller. All datapath muxing, including PC-source selection, stays outside this block and is driven by `pc_src`.

## Interface
Parameters: none.

Ports (clock and reset first):
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- intr  in  1  level interrupt request, held until `intr_ack`
- int_en  in  1  global interrupt enable
- branch_taken  in  1  conditional branch resolved taken in ID
- jump  in  1  jump/jal/jr decoded in ID
- load_use  in  1  load-use hazard detected in ID
- reti  in  1  return-from-interrupt decoded in ID
- halt  in  1  break/halt decoded in ID
- pc_ld  out  1  load PC from external mux
- pc_inc  out  1  PC += 4
- pc_src  out  2  PC mux select: 0 branch target, 1 jump target, 2 ISR vector, 3 restored PC
- Stall  out  1  hold IF/ID register
- Flush  out  1  zero IF/ID register
- im_cs, im_rd  out  1 each  instruction memory chip-select/read
- im_wr  out  1  tied 0
- ISR  out  1  interrupt-entry in progress
- LISR  out  3  interrupt-exit phase, one-hot
- intr_ack  out  1  interrupt accepted, one-cycle pulse
- save_pc  out  1  push PC to interrupt stack, one-cycle pulse
- restore_pc  out  1  pop saved PC, one-cycle pulse
- in_isr  out  1  executing inside an ISR
- halted  out  1  core halted

## Operation
- States: IDLE, RUN, ISR_SAVE, ISR_VEC, LISR_1, LISR_2, LISR_3, HALT. Binary encoding; the state register and `in_isr` are the only flops.
- Outputs are combinational from state and inputs. Every output not listed for a state/condition is 0.
- IDLE: all outputs 0. Next state is RUN unconditionally.
- RUN: `im_cs`=`im_rd`=1. Fixed priority, highest first:
  1. halt: `Stall`=1. Next HALT.
  2. reti with `in_isr`=1: `Flush`=1. Next LISR_1. A reti with `in_isr`=0 is a NOP and falls to the lower priorities.
  3. branch_taken or jump: `pc_ld`=1, `Flush`=1, `pc_src`=0 for a branch, 1 for a jump. Jump wins if both are asserted. Stay in RUN.
  4. intr & int_en & !in_isr: `intr_ack`=1, `Stall`=1. Next ISR_SAVE.
  5. load_use: `Stall`=1. Stay in RUN.
  6. Otherwise: `pc_inc`=1.
- ISR_SAVE: `ISR`=1, `save_pc`=1, `Stall`=1. Next ISR_VEC.
- ISR_VEC: `ISR`=1, `pc_ld`=1, `pc_src`=2, `Flush`=1. Set `in_isr`. Next RUN.
- LISR_1: `LISR`=001, `Stall`=1. Next LISR_2.
- LISR_2: `LISR`=010, `Stall`=1, `restore_pc`=1. Next LISR_3.
- LISR_3: `LISR`=100, `pc_ld`=1, `pc_src`=3, `Flush`=1. Clear `in_isr`. Next RUN.
- HALT: `halted`=1, `im_cs`=`im_rd`=0, `Stall`=1.
  - On intr & int_en & !in_isr: `intr_ack`=1, next ISR_SAVE.
  - Otherwise stay in HALT; only reset also exits.
- No interrupt nesting. While `in_isr`=1, intr is ignored and stays pending.
- All RUN-state decision inputs (halt, reti, branch_taken, jump, intr, load_use) are ignored in ISR_SAVE, ISR_VEC and LISR_1..3; these sequences always complete. In HALT only intr/int_en are evaluated.

## Timing
- Reset: state IDLE, `in_isr`=0, all outputs 0. Reset deassertion to first `pc_inc`: exactly 1 cycle (IDLE), then RUN.
- Decision latency: zero. Strobes in RUN respond in the same cycle as the ID-stage input; the state update takes effect on the next rising edge.
- Interrupt entry: accept cycle (RUN or HALT) plus ISR_SAVE plus ISR_VEC = 3 cycles from the `intr_ack` cycle to the vector `pc_ld`. The first ISR fetch is in the following cycle.
- Interrupt exit: reti cycle plus LISR_1..3 = 4 cycles to the restored `pc_ld`.
- Branch/jump coincident with intr: branch/jump is taken; intr is accepted the next RUN cycle, provided it is still asserted.
- Reset asserted mid-sequence (ISR_*, LISR_*, HALT): immediate return to IDLE with `in_isr` cleared. No partial pulses after the reset edge.
- `pc_ld` and `pc_inc` are never both 1. `Flush` and `Stall` are never both 1. `LISR` is always one-hot or zero.

## Test plan
- Reset release with all inputs 0 → cycle 0 all outputs 0; cycle 1 onward `pc_inc`=1, `im_cs`=`im_rd`=1.
- branch_taken=1 for one cycle in RUN → that cycle `pc_ld`=1, `pc_src`=0, `Flush`=1, `pc_inc`=0; next cycle `pc_inc`=1. Repeat with jump=1 → `pc_src`=1.
- load_use=1 for 2 cycles → `Stall`=1, `pc_inc`=0 for exactly those 2 cycles.
- int_en=1, intr=1 held → `intr_ack` pulse, then `ISR`=1 with `save_pc`, then `pc_ld` with `pc_src`=2 and `in_isr`=1. A second intr while `in_isr`=1 produces no `intr_ack`.
- reti with `in_isr`=1 → `Flush`, then `LISR`=001, 010 (with `restore_pc`), 100 (with `pc_ld`, `pc_src`=3), then `in_isr`=0. reti with `in_isr`=0 → `pc_inc`=1 only.
- halt → `halted`=1, `im_cs`=0; a later intr & int_en wakes the core through the 3-cycle entry sequence. Reset asserted during LISR_2 → IDLE, all outputs 0 and `in_isr`=0 in the same cycle.
